// File: rtl/turbo_pkg.sv
// Shared types and defaults for the turbo encoder frame sequencer and the QPP address generator.
package turbo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ENC   = 3'd2,
    ST_TAIL1 = 3'd3,
    ST_TAIL2 = 3'd4
  } state_t;

  localparam logic [1:0] TAIL_DATA = 2'b00;
  localparam logic [1:0] TAIL_ENC1 = 2'b01;
  localparam logic [1:0] TAIL_ENC2 = 2'b10;

  localparam int DEF_K        = 40;
  localparam int DEF_F1       = 3;
  localparam int DEF_F2       = 10;
  localparam int DEF_TAIL_LEN = 3;

endpackage

// File: rtl/turbo_frame_ctrl_qpp_addr_gen.sv
// Multiplier-free QPP interleaver address generator: pi(i) = (F1*i + F2*i^2) mod K, one index per adv.
module qpp_addr_gen
  import turbo_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int F1     = DEF_F1,
  parameter int F2     = DEF_F2,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W:0]   K_W    = (ADDR_W+1)'(K);
  localparam logic [ADDR_W-1:0] G_INIT = ADDR_W'((F1 + F2) % K);
  localparam logic [ADDR_W-1:0] G_STEP = ADDR_W'((2 * F2) % K);

  logic [ADDR_W-1:0] pi;
  logic [ADDR_W-1:0] g;

  // Both operands are below K, so one conditional subtract completes the reduction.
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= K_W) s = s - K_W;
    return s[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi <= '0;
      g  <= G_INIT;
    end else if (init) begin
      pi <= '0;
      g  <= G_INIT;
    end else if (adv) begin
      pi <= mod_add(pi, g);
      g  <= mod_add(g, G_STEP);
    end
  end

  assign addr = pi;

endmodule

// File: rtl/turbo_frame_ctrl.sv
// Turbo encoder frame sequencer: load K bits, step both RSC encoders, terminate each, flag done.
// Optional TURBO_FRAME_CNT_EN adds an 8-bit completed-frame counter output frame_cnt.
module turbo_frame_ctrl
  import turbo_pkg::*;
#(
  parameter int K        = DEF_K,
  parameter int F1       = DEF_F1,
  parameter int F2       = DEF_F2,
  parameter int ADDR_W   = 6,
  parameter int TAIL_LEN = DEF_TAIL_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr_nat,
  output logic [ADDR_W-1:0] rd_addr_int,
  output logic              enc_clr,
  output logic              step,
  output logic [1:0]        tail_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
`ifdef TURBO_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  localparam int TW = $clog2(TAIL_LEN + 1);
  localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(K - 1);
  localparam logic [TW-1:0]     TAIL_LAST = TW'(TAIL_LEN - 1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high and ena is
  // high; valid never depends on ready, and out_valid stays up under backpressure.

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] load_cnt;
  logic [ADDR_W-1:0] i_cnt;
  logic [TW-1:0]     tail_cnt;
  logic              tail_last;
  logic              clr_all;
  logic              qpp_init;
  logic              qpp_adv;

  assign tail_last = (tail_cnt == TAIL_LAST);
  assign clr_all   = ena && (abort || (state == ST_IDLE && start));
  // Re-arm the interleaver at frame start, on abort, and once the data phase is finished.
  assign qpp_init  = clr_all || (step && state == ST_ENC && i_cnt == K_LAST);
  assign qpp_adv   = step && state == ST_ENC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= ST_IDLE;
    else if (ena) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  if (wr_en && load_cnt == K_LAST) state_next = ST_ENC;
      ST_ENC:   if (step && i_cnt == K_LAST) state_next = ST_TAIL1;
      ST_TAIL1: if (step && tail_last) state_next = ST_TAIL2;
      ST_TAIL2: if (step && tail_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    tail_sel  = TAIL_DATA;
    case (state)
      ST_LOAD:  in_ready = 1'b1;
      ST_ENC:   out_valid = 1'b1;
      ST_TAIL1: begin
        out_valid = 1'b1;
        tail_sel  = TAIL_ENC1;
      end
      ST_TAIL2: begin
        out_valid = 1'b1;
        tail_sel  = TAIL_ENC2;
      end
      default: ;
    endcase
    busy    = (state != ST_IDLE);
    wr_en   = ena && in_valid && in_ready;
    step    = ena && out_valid && out_ready;
    enc_clr = ena && state == ST_IDLE && start && !abort;
    done    = step && state == ST_TAIL2 && tail_last && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
      i_cnt    <= '0;
      tail_cnt <= '0;
    end else if (ena) begin
      if (clr_all) begin
        load_cnt <= '0;
        i_cnt    <= '0;
        tail_cnt <= '0;
      end else begin
        if (wr_en) load_cnt <= (load_cnt == K_LAST) ? '0 : load_cnt + 1'b1;
        if (step) begin
          if (state == ST_ENC) i_cnt <= (i_cnt == K_LAST) ? '0 : i_cnt + 1'b1;
          else tail_cnt <= tail_last ? '0 : tail_cnt + 1'b1;
        end
      end
    end
  end

  qpp_addr_gen #(
    .K      (K),
    .F1     (F1),
    .F2     (F2),
    .ADDR_W (ADDR_W)
  ) u_qpp (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (qpp_init),
    .adv   (qpp_adv),
    .addr  (rd_addr_int)
  );

  assign wr_addr     = load_cnt;
  assign rd_addr_nat = i_cnt;
  assign dbg_state   = state;

`ifdef TURBO_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    frame_cnt <= 8'd0;
    else if (done) frame_cnt <= frame_cnt + 8'd1;
  end
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// Self-checking bench for turbo_frame_ctrl: control vector table, reference-model frame runs, mid-load reset.
module tb_turbo_frame_ctrl;
  import turbo_pkg::*;

  localparam int K     = DEF_K;
  localparam int F1    = DEF_F1;
  localparam int F2    = DEF_F2;
  localparam int AW    = 6;
  localparam int TL    = DEF_TAIL_LEN;
  localparam int TOTAL = K + 2 * TL;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr_nat;
  logic [AW-1:0] rd_addr_int;
  logic          enc_clr;
  logic          step;
  logic [1:0]    tail_sel;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  state_t        dbg_state;
`ifdef TURBO_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
`endif

  turbo_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr_nat (rd_addr_nat),
    .rd_addr_int (rd_addr_int),
    .enc_clr     (enc_clr),
    .step        (step),
    .tail_sel    (tail_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
`ifdef TURBO_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int frames_model = 0;
  logic [13:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qpp(input int i);
    return (F1 * i + F2 * i * i) % K;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    start     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ena       = 1'b1;
  endtask

  task automatic apply_reset();
    drive_quiet();
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    frames_model = 0;
    tick();
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       ena;
    logic       exp_busy;
    logic       exp_in_ready;
    logic       exp_wr_en;
    logic       exp_enc_clr;
    logic [5:0] exp_wr_addr;
  } vec_t;

  vec_t vt[12];

  task automatic run_table();
    for (int n = 0; n < 12; n++) begin
      start    = vt[n].start;
      abort    = vt[n].abort;
      in_valid = vt[n].in_valid;
      ena      = vt[n].ena;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d busy", n), busy, vt[n].exp_busy);
      chk($sformatf("tbl%0d in_ready", n), in_ready, vt[n].exp_in_ready);
      chk($sformatf("tbl%0d wr_en", n), wr_en, vt[n].exp_wr_en);
      chk($sformatf("tbl%0d enc_clr", n), enc_clr, vt[n].exp_enc_clr);
      chk($sformatf("tbl%0d wr_addr", n), wr_addr, vt[n].exp_wr_addr);
      tick();
    end
    drive_quiet();
  endtask

  // mode 0: always ready, 1: out_ready toggles 1010.., 2: random in_valid/out_ready
  task automatic run_frame(input int mode, input int abort_at);
    int acc_bits = 0;
    int steps = 0;
    int ir_cycles = 0;
    int ov_cycles = 0;
    bit tog = 1'b1;
    bit finished = 1'b0;
    bit aborted = 1'b0;
    bit ir_exp, ov_exp, take;
    logic [13:0] e;
    exp_q.delete();
    for (int i = 0; i < K; i++) exp_q.push_back({2'b00, 6'(i), 6'(qpp(i))});
    for (int t = 0; t < TL; t++) exp_q.push_back({2'b01, 12'd0});
    for (int t = 0; t < TL; t++) exp_q.push_back({2'b10, 12'd0});

    drive_quiet();
    start = 1'b1;
    @(negedge clk);
    chk("start enc_clr", enc_clr, 1'b1);
    chk("start busy", busy, 1'b0);
    tick();
    start = 1'b0;

    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      in_valid  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog       = ~tog;
      abort     = (abort_at >= 0 && acc_bits == K && steps == abort_at);
      ir_exp    = (acc_bits < K);
      ov_exp    = (acc_bits == K && steps < TOTAL);
      @(negedge clk);
      chk("busy", busy, 1'b1);
      chk("in_ready", in_ready, ir_exp);
      chk("out_valid", out_valid, ov_exp);
      chk("wr_en", wr_en, in_valid && ir_exp);
      take = out_ready && ov_exp;
      chk("step", step, take);
      if (in_ready) ir_cycles++;
      if (out_valid) ov_cycles++;
      if (in_valid && ir_exp) begin
        chk("wr_addr", wr_addr, acc_bits);
        acc_bits++;
      end
      if (take) begin
        e = exp_q.pop_front();
        chk("tail_sel", tail_sel, e[13:12]);
        if (e[13:12] == 2'b00) begin
          chk("rd_addr_nat", rd_addr_nat, e[11:6]);
          chk("rd_addr_int", rd_addr_int, e[5:0]);
        end
        steps++;
      end
      chk("done", done, take && steps == TOTAL && !abort);
      if (abort) begin
        aborted  = 1'b1;
        finished = 1'b1;
      end else if (steps == TOTAL) begin
        finished = 1'b1;
      end
      tick();
    end
    if (!finished) chk("frame timeout", 1'b0, 1'b1);

    drive_quiet();
    @(negedge clk);
    chk("post busy", busy, 1'b0);
    chk("post out_valid", out_valid, 1'b0);
    chk("post in_ready", in_ready, 1'b0);
    chk("post done", done, 1'b0);
    if (!aborted) begin
      frames_model++;
      chk("frame steps", steps, TOTAL);
      if (mode == 0) begin
        chk("in_ready cycles", ir_cycles, K);
        chk("enc cycles to done", ov_cycles, TOTAL);
      end
    end
    tick();
  endtask

  task automatic reset_in_load();
    drive_quiet();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 17; b++) begin
      in_valid = 1'b1;
      start    = (b == 8);
      @(negedge clk);
      chk("load wr_addr", wr_addr, b);
      chk("load start ignored", enc_clr, 1'b0);
      tick();
    end
    drive_quiet();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst tail_sel", tail_sel, 2'b00);
    chk("rst rd_addr_int", rd_addr_int, 0);
    chk("rst done", done, 1'b0);
    frames_model = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- main ----------------
  initial begin
    //        start abort in_v ena  busy ir   wr   clr  wa
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd2};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};

    apply_reset();
    @(negedge clk);
    chk("reset state", dbg_state, ST_IDLE);
    chk("reset busy", busy, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset tail_sel", tail_sel, 2'b00);
    chk("reset rd_addr_nat", rd_addr_nat, 0);
    chk("reset rd_addr_int", rd_addr_int, 0);
`ifdef TURBO_FRAME_CNT_EN
    chk("reset frame_cnt", frame_cnt, 0);
`endif
    tick();

    run_table();
    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(0, 20);
    run_frame(0, -1);
    for (int r = 0; r < 3; r++) run_frame(2, -1);
`ifdef TURBO_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, frames_model);
`endif
    reset_in_load();
    run_frame(0, -1);
`ifdef TURBO_FRAME_CNT_EN
    chk("frame_cnt after reset", frame_cnt, frames_model);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
